// File: rtl/pwm_breath_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_breath_ctrl
// Purpose  : Envelope sequencer for the shared PWM duty generator. It runs a
//            programmable RISE / HOLD_HI / FALL / HOLD_LO breathing cycle and
//            drives the duty value for a pwm(.value) input. It has its own
//            tick prescaler, so it runs directly on the board clock. The cycle
//            can repeat continuously or run once (one-shot).
// Ports    : clk_i         system clock
//            rst_ni        asynchronous active-low reset
//            en_i          run enable; low forces IDLE
//            oneshot_i     1: stop in IDLE after one cycle, 0: repeat
//            step_i        duty increment per tick (0 is treated as 1)
//            hold_hi_i     extra ticks held at RANGE
//            hold_lo_i     extra ticks held at 0
//            pwm_value_o   registered duty value
//            busy_o        high in any state except IDLE
//            cycle_done_o  1-clk pulse at the end of each full cycle
//            state_o       IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4
// Revision : 1.0  initial release
// ============================================================================
module pwm_breath_ctrl #(
  parameter int BITS     = 10,
  parameter int RANGE    = 999,
  parameter int TICK_W   = 14,
  parameter int TICK_DIV = 12000,
  parameter int HOLD_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              oneshot_i,
  input  logic [BITS-1:0]   step_i,
  input  logic [HOLD_W-1:0] hold_hi_i,
  input  logic [HOLD_W-1:0] hold_lo_i,
  output logic [BITS-1:0]   pwm_value_o,
  output logic              busy_o,
  output logic              cycle_done_o,
  output logic [2:0]        state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RISE    = 3'd1;
  localparam logic [2:0] S_HOLD_HI = 3'd2;
  localparam logic [2:0] S_FALL    = 3'd3;
  localparam logic [2:0] S_HOLD_LO = 3'd4;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [BITS:0]     RANGE_X   = (BITS+1)'(RANGE);
  localparam logic [BITS-1:0]   RANGE_V   = BITS'(RANGE);

  logic [2:0]        state_q, state_d;
  logic [BITS-1:0]   pwm_q, pwm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [BITS-1:0]   step_sh_q, step_sh_d;
  logic [HOLD_W-1:0] hold_hi_sh_q, hold_hi_sh_d;
  logic [HOLD_W-1:0] hold_lo_sh_q, hold_lo_sh_d;
  logic              oneshot_sh_q, oneshot_sh_d;
  // Cleared when a one-shot cycle finishes; set again only while en is low,
  // so a new one-shot run needs en to drop and rise again.
  logic              armed_q, armed_d;

  logic              tick;
  logic [BITS-1:0]   eff_step;
  logic [BITS:0]     sum;

  assign tick     = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
  assign eff_step = (step_sh_q == '0) ? BITS'(1) : step_sh_q;
  // One bit wider than the duty so a large step cannot wrap past RANGE.
  assign sum      = {1'b0, pwm_q} + {1'b0, eff_step};

  always_comb begin
    state_d      = state_q;
    pwm_d        = pwm_q;
    done_d       = 1'b0;
    tick_cnt_d   = tick_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    step_sh_d    = step_sh_q;
    hold_hi_sh_d = hold_hi_sh_q;
    hold_lo_sh_d = hold_lo_sh_q;
    oneshot_sh_d = oneshot_sh_q;
    armed_d      = armed_q;

    if (!en_i) begin
      // Disable overrides everything, including a coincident cycle-end tick.
      state_d    = S_IDLE;
      pwm_d      = '0;
      tick_cnt_d = '0;
      hold_cnt_d = '0;
      armed_d    = 1'b1;
    end else begin
      if (state_q != S_IDLE) begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          pwm_d      = '0;
          tick_cnt_d = '0;
          hold_cnt_d = '0;
          if (armed_q) begin
            state_d      = S_RISE;
            step_sh_d    = step_i;
            hold_hi_sh_d = hold_hi_i;
            hold_lo_sh_d = hold_lo_i;
            oneshot_sh_d = oneshot_i;
          end
        end

        S_RISE: begin
          if (tick) begin
            if (sum >= RANGE_X) begin
              pwm_d      = RANGE_V;
              hold_cnt_d = '0;
              state_d    = S_HOLD_HI;
            end else begin
              pwm_d = sum[BITS-1:0];
            end
          end
        end

        S_HOLD_HI: begin
          if (tick) begin
            if (hold_cnt_q == hold_hi_sh_q) begin
              state_d = S_FALL;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end

        S_FALL: begin
          if (tick) begin
            if (pwm_q <= eff_step) begin
              pwm_d      = '0;
              hold_cnt_d = '0;
              state_d    = S_HOLD_LO;
            end else begin
              pwm_d = pwm_q - eff_step;
            end
          end
        end

        S_HOLD_LO: begin
          if (tick) begin
            if (hold_cnt_q == hold_lo_sh_q) begin
              done_d     = 1'b1;
              hold_cnt_d = '0;
              if (oneshot_sh_q) begin
                state_d = S_IDLE;
                armed_d = 1'b0;
              end else begin
                // Inputs changed mid-cycle are picked up here.
                state_d      = S_RISE;
                step_sh_d    = step_i;
                hold_hi_sh_d = hold_hi_i;
                hold_lo_sh_d = hold_lo_i;
                oneshot_sh_d = oneshot_i;
              end
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end

        default: begin
          state_d    = S_IDLE;
          pwm_d      = '0;
          tick_cnt_d = '0;
          hold_cnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pwm_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tick_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      step_sh_q    <= '0;
      hold_hi_sh_q <= '0;
      hold_lo_sh_q <= '0;
      oneshot_sh_q <= 1'b0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      pwm_q        <= pwm_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tick_cnt_q   <= tick_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      step_sh_q    <= step_sh_d;
      hold_hi_sh_q <= hold_hi_sh_d;
      hold_lo_sh_q <= hold_lo_sh_d;
      oneshot_sh_q <= oneshot_sh_d;
      armed_q      <= armed_d;
    end
  end

  assign pwm_value_o  = pwm_q;
  assign busy_o       = busy_q;
  assign cycle_done_o = done_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_breath_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_breath_ctrl
// Purpose  : Directed self-checking bench for pwm_breath_ctrl with
//            TICK_DIV=4, RANGE=10, BITS=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_breath_ctrl;

  localparam int BITS   = 4;
  localparam int HOLD_W = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              oneshot;
  logic [BITS-1:0]   step;
  logic [HOLD_W-1:0] hold_hi;
  logic [HOLD_W-1:0] hold_lo;
  logic [BITS-1:0]   pwm_value;
  logic              busy;
  logic              cycle_done;
  logic [2:0]        state;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_ref;
  int hold_len;

  pwm_breath_ctrl #(
    .BITS    (BITS),
    .RANGE   (10),
    .TICK_W  (3),
    .TICK_DIV(4),
    .HOLD_W  (HOLD_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .oneshot_i   (oneshot),
    .step_i      (step),
    .hold_hi_i   (hold_hi),
    .hold_lo_i   (hold_lo),
    .pwm_value_o (pwm_value),
    .busy_o      (busy),
    .cycle_done_o(cycle_done),
    .state_o     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cycle_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [BITS-1:0] s, input logic [HOLD_W-1:0] hh,
                       input logic [HOLD_W-1:0] hl, input logic os);
    en = 1'b0;
    clks(1);
    step = s; hold_hi = hh; hold_lo = hl; oneshot = os; en = 1'b1;
    clks(1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; oneshot = 1'b0; step = '0; hold_hi = '0; hold_lo = '0;
    #12;
    chk("reset_state", 32'(state), 0);
    chk("reset_pwm", 32'(pwm_value), 0);
    rst_n = 1'b1;
    clks(1);

    // 1: asynchronous reset in the middle of RISE
    start(4'd3, 4'd0, 4'd0, 1'b0);
    chk("t1_enter_rise", 32'(state), 1);
    clks(8);
    chk("t1_pwm_before", 32'(pwm_value), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_pwm", 32'(pwm_value), 0);
    chk("t1_rst_state", 32'(state), 0);
    chk("t1_rst_busy", 32'(busy), 0);
    chk("t1_rst_done", 32'(cycle_done), 0);
    en = 1'b0;
    clks(1);
    rst_n = 1'b1;
    clks(1);

    // 2: one-shot, step=3, no holds
    done_ref = done_cnt;
    start(4'd3, 4'd0, 4'd0, 1'b1);
    chk("t2_rise_state", 32'(state), 1);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_pwm0", 32'(pwm_value), 0);
    clks(4);  chk("t2_pwm3", 32'(pwm_value), 3);
    clks(4);  chk("t2_pwm6", 32'(pwm_value), 6);
    clks(4);  chk("t2_pwm9", 32'(pwm_value), 9);
    clks(4);  chk("t2_pwm10a", 32'(pwm_value), 10);
    chk("t2_holdhi", 32'(state), 2);
    clks(4);  chk("t2_pwm10b", 32'(pwm_value), 10);
    chk("t2_fall", 32'(state), 3);
    clks(4);  chk("t2_pwm7", 32'(pwm_value), 7);
    clks(4);  chk("t2_pwm4", 32'(pwm_value), 4);
    clks(4);  chk("t2_pwm1", 32'(pwm_value), 1);
    clks(4);  chk("t2_pwm0b", 32'(pwm_value), 0);
    chk("t2_holdlo", 32'(state), 4);
    chk("t2_no_done_yet", 32'(cycle_done), 0);
    clks(4);  chk("t2_done", 32'(cycle_done), 1);
    chk("t2_idle", 32'(state), 0);
    chk("t2_busy_low", 32'(busy), 0);
    clks(1);  chk("t2_done_pulse", 32'(cycle_done), 0);
    clks(12);
    chk("t2_no_restart", 32'(state), 0);
    chk("t2_done_count", 32'(done_cnt - done_ref), 1);

    // 3: step=0 behaves as 1, hold_hi=2
    start(4'd0, 4'd2, 4'd0, 1'b1);
    clks(36); chk("t3_pwm9", 32'(pwm_value), 9);
    clks(4);  chk("t3_pwm10", 32'(pwm_value), 10);
    chk("t3_holdhi", 32'(state), 2);
    hold_len = 0;
    while (state === 3'd2 && hold_len < 40) begin
      clks(1);
      hold_len++;
    end
    chk("t3_hold_clks", 32'(hold_len), 12);
    chk("t3_fall", 32'(state), 3);
    chk("t3_pwm_fall0", 32'(pwm_value), 10);
    clks(4);  chk("t3_pwm_fall1", 32'(pwm_value), 9);

    // 4: step larger than RANGE saturates in one tick each way
    start(4'd15, 4'd0, 4'd0, 1'b1);
    clks(4);  chk("t4_pwm_top", 32'(pwm_value), 10);
    chk("t4_holdhi", 32'(state), 2);
    clks(4);  chk("t4_fall", 32'(state), 3);
    clks(4);  chk("t4_pwm_bot", 32'(pwm_value), 0);
    chk("t4_holdlo", 32'(state), 4);
    clks(4);  chk("t4_done", 32'(cycle_done), 1);
    chk("t4_idle", 32'(state), 0);

    // 5: continuous, step changed mid-FALL takes effect next cycle
    start(4'd2, 4'd0, 4'd0, 1'b0);
    done_ref = done_cnt;
    clks(28); chk("t5_pwm8", 32'(pwm_value), 8);
    chk("t5_fall", 32'(state), 3);
    step = 4'd5;
    clks(4);  chk("t5_pwm6", 32'(pwm_value), 6);
    clks(12); chk("t5_pwm0", 32'(pwm_value), 0);
    chk("t5_holdlo", 32'(state), 4);
    clks(4);  chk("t5_done1", 32'(cycle_done), 1);
    chk("t5_rerise", 32'(state), 1);
    clks(4);  chk("t5_pwm5", 32'(pwm_value), 5);
    clks(4);  chk("t5_pwm10", 32'(pwm_value), 10);
    clks(8);  chk("t5_pwm5f", 32'(pwm_value), 5);
    clks(4);  chk("t5_pwm0b", 32'(pwm_value), 0);
    clks(4);  chk("t5_done2", 32'(cycle_done), 1);
    clks(1);  chk("t5_done_count", 32'(done_cnt - done_ref), 2);

    // 6: en dropped exactly on the cycle-end tick clock
    start(4'd15, 4'd0, 4'd0, 1'b0);
    done_ref = done_cnt;
    clks(12); chk("t6_holdlo", 32'(state), 4);
    clks(3);
    en = 1'b0;
    clks(1);
    chk("t6_idle", 32'(state), 0);
    chk("t6_pwm", 32'(pwm_value), 0);
    chk("t6_no_done", 32'(cycle_done), 0);
    chk("t6_busy", 32'(busy), 0);
    en = 1'b1;
    clks(1);
    chk("t6_rerise", 32'(state), 1);
    chk("t6_done_count", 32'(done_cnt - done_ref), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
